uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (tx_start / tx_data / tx_busy handshake) among N on-chip byte producers, e.g. the matmul, qsort and fir result streams.
- Round-robin arbitration; a granted requester may send a bounded burst of bytes before the grant rotates.
- A busy-rise watchdog stops a missing or stuck UART from hanging the arbiter.
- Sits in the user project between the workload engines and the UART TX.

---
 rtl/uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte producers, with bounded
// bursts and a busy-rise watchdog. Define UART_TX_TAG_EN to prefix each grant with a header byte.
module uart_tx_arbiter #(
    parameter int unsigned N         = 3,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic [2:0]       grant_id,
    output logic             arb_busy,
    output logic             err_timeout,
    output logic [15:0]      sent_cnt
);

    localparam int unsigned    WdW      = $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLast   = WdW'(TIMEOUT - 1);
    localparam logic [2:0]     LastIdx  = 3'(N - 1);
    localparam logic [7:0]     BurstMax = 8'(MAX_BURST);

`ifdef UART_TX_TAG_EN
    typedef enum logic [2:0] {StIdle, StStart, StWait, StDone, StTag} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StWait, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [WdW-1:0]   wd_cnt_q, wd_cnt_d;
    logic [15:0]      sent_cnt_q, sent_cnt_d;
    logic             err_timeout_q, err_timeout_d;
`ifdef UART_TX_TAG_EN
    logic [7:0]       hold_q, hold_d;
    logic             hdr_q, hdr_d;
`endif

    logic             arb_found;
    logic [2:0]       arb_idx;
    logic [7:0]       win_byte;
    logic [7:0]       own_byte;
    logic             own_valid;
    logic             ready_hit;
    logic [2:0]       ready_idx;
    logic [2:0]       next_ptr;

    // Two passes give the wrap-around scan: first rr_ptr..N-1, then 0..rr_ptr-1.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!arb_found && (3'(i) >= rr_ptr_q) && req_valid[i]) begin
                arb_found = 1'b1;
                arb_idx   = 3'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!arb_found && (3'(i) < rr_ptr_q) && req_valid[i]) begin
                arb_found = 1'b1;
                arb_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        win_byte  = '0;
        own_byte  = '0;
        own_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (3'(i) == arb_idx) begin
                win_byte = req_data[8*i +: 8];
            end
            if (3'(i) == grant_id_q) begin
                own_byte  = req_data[8*i +: 8];
                own_valid = req_valid[i];
            end
        end
    end

    assign next_ptr = (grant_id_q == LastIdx) ? 3'd0 : grant_id_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        burst_cnt_d   = burst_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        sent_cnt_d    = sent_cnt_q;
        err_timeout_d = 1'b0;
        ready_hit     = 1'b0;
        ready_idx     = '0;
`ifdef UART_TX_TAG_EN
        hold_d        = hold_q;
        hdr_d         = hdr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    ready_hit   = 1'b1;
                    ready_idx   = arb_idx;
                    grant_id_d  = arb_idx;
                    burst_cnt_d = 8'd1;
                    wd_cnt_d    = '0;
`ifdef UART_TX_TAG_EN
                    hold_d      = win_byte;
                    state_d     = StTag;
`else
                    tx_data_d   = win_byte;
                    state_d     = StStart;
`endif
                end
            end
`ifdef UART_TX_TAG_EN
            StTag: begin
                tx_data_d = 8'hA0 | {5'b0, grant_id_q};
                hdr_d     = 1'b1;
                wd_cnt_d  = '0;
                state_d   = StStart;
            end
`endif
            StStart: begin
                if (tx_busy) begin
                    state_d = StWait;
                end else if (wd_cnt_q == WdLast) begin
                    // UART never answered: drop the byte (and header) and move on.
                    err_timeout_d = 1'b1;
                    rr_ptr_d      = next_ptr;
                    state_d       = StIdle;
`ifdef UART_TX_TAG_EN
                    hdr_d         = 1'b0;
`endif
                end else begin
                    wd_cnt_d = wd_cnt_q + WdW'(1);
                end
            end
            StWait: begin
                if (!tx_busy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                sent_cnt_d = sent_cnt_q + 16'd1;
`ifdef UART_TX_TAG_EN
                if (hdr_q) begin
                    hdr_d     = 1'b0;
                    tx_data_d = hold_q;
                    wd_cnt_d  = '0;
                    state_d   = StStart;
                end else
`endif
                if (own_valid && (burst_cnt_q < BurstMax)) begin
                    ready_hit   = 1'b1;
                    ready_idx   = grant_id_q;
                    tx_data_d   = own_byte;
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    wd_cnt_d    = '0;
                    state_d     = StStart;
                end else begin
                    rr_ptr_d = next_ptr;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            burst_cnt_q   <= '0;
            wd_cnt_q      <= '0;
            sent_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
`ifdef UART_TX_TAG_EN
            hold_q        <= '0;
            hdr_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            burst_cnt_q   <= burst_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            sent_cnt_q    <= sent_cnt_d;
            err_timeout_q <= err_timeout_d;
`ifdef UART_TX_TAG_EN
            hold_q        <= hold_d;
            hdr_q         <= hdr_d;
`endif
        end
    end

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            req_ready[i] = ready_hit && (3'(i) == ready_idx);
        end
    end

    assign tx_start    = (state_q == StStart);
    assign arb_busy    = (state_q != StIdle);
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_timeout_q;
    assign sent_cnt    = sent_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a transaction-level model predicts every output each
// cycle, and directed scenarios pin byte order, watchdog latency and async reset.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned MB = 4;
    localparam int unsigned TO = 16;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_WAIT  = 2;
    localparam int P_DONE  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [2:0]     grant_id;
    logic           arb_busy;
    logic           err_timeout;
    logic [15:0]    sent_cnt;

    uart_tx_arbiter #(.N(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .err_timeout(err_timeout),
        .sent_cnt   (sent_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Requester byte queues (circular buffers).
    logic [7:0] rq_mem [N][64];
    int         rq_head [N];
    int         rq_cnt  [N];
    bit         rq_en   [N];

    // Behavioural model of the arbiter.
    int          m_phase;
    int          m_rr;
    int          m_grant;
    int          m_burst;
    logic [7:0]  m_data;
    logic [15:0] m_sent;
    bit          m_err;
    longint      m_start;
    longint      cyc;

    // UART model.
    int         u_wait;
    int         u_left;
    bit         u_ignore;
    bit         u_dead;
    bit         u_rand;
    int         u_hold;
    logic [7:0] u_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < u_log.size()) return {24'd0, u_log[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic push(input int i, input logic [7:0] b);
        rq_mem[i][(rq_head[i] + rq_cnt[i]) % 64] = b;
        rq_cnt[i]++;
    endtask

    task automatic pop(input int i);
        rq_head[i] = (rq_head[i] + 1) % 64;
        rq_cnt[i]--;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            rq_head[i] = 0;
            rq_cnt[i]  = 0;
            rq_en[i]   = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_rr    = 0;
        m_grant = 0;
        m_burst = 0;
        m_data  = 8'h00;
        m_sent  = 16'h0000;
        m_err   = 1'b0;
        m_start = 0;
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit cont_ok();
        return req_valid[m_grant] && (m_burst < MB);
    endfunction

    task automatic model_compare();
        logic [N-1:0] exp_ready;
        int w;
        w = winner();
        exp_ready = '0;
        if (m_phase == P_IDLE && w >= 0) exp_ready[w] = 1'b1;
        if (m_phase == P_DONE && cont_ok()) exp_ready[m_grant] = 1'b1;
        check("req_ready", {29'd0, req_ready}, {29'd0, exp_ready});
        check("tx_start", {31'd0, tx_start}, {31'd0, m_phase == P_START});
        check("tx_data", {24'd0, tx_data}, {24'd0, m_data});
        check("grant_id", {29'd0, grant_id}, m_grant);
        check("arb_busy", {31'd0, arb_busy}, {31'd0, m_phase != P_IDLE});
        check("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
        check("sent_cnt", {16'd0, sent_cnt}, {16'd0, m_sent});
    endtask

    task automatic model_step();
        int w;
        bit c;
        w = winner();
        c = cont_ok();
        cyc++;
        m_err = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (w >= 0) begin
                    m_grant = w;
                    m_data  = req_data[8*w +: 8];
                    m_burst = 1;
                    m_start = cyc;
                    m_phase = P_START;
                    pop(w);
                end
            end
            P_START: begin
                if (tx_busy) begin
                    m_phase = P_WAIT;
                end else if (cyc - m_start == TO) begin
                    m_err   = 1'b1;
                    m_rr    = (m_grant + 1) % N;
                    m_phase = P_IDLE;
                end
            end
            P_WAIT: if (!tx_busy) m_phase = P_DONE;
            default: begin
                m_sent++;
                if (c) begin
                    m_data  = req_data[8*m_grant +: 8];
                    m_burst++;
                    m_start = cyc;
                    m_phase = P_START;
                    pop(m_grant);
                end else begin
                    m_rr    = (m_grant + 1) % N;
                    m_phase = P_IDLE;
                end
            end
        endcase
    endtask

    task automatic uart_step();
        if (tx_busy) begin
            u_left--;
            if (u_left <= 0) tx_busy = 1'b0;
        end else begin
            if (!tx_start) u_ignore = 1'b0;
            if (u_wait < 0 && tx_start && !u_ignore) begin
                if (u_dead || (u_rand && $urandom_range(0, 9) == 0)) u_ignore = 1'b1;
                else u_wait = u_rand ? int'($urandom_range(0, 3)) : 1;
            end
            if (u_wait == 0) begin
                tx_busy = 1'b1;
                u_left  = (u_hold > 0) ? u_hold : int'($urandom_range(1, 5));
                u_log.push_back(tx_data);
                u_wait  = -1;
            end else if (u_wait > 0) begin
                u_wait--;
            end
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (rq_en[i] && rq_cnt[i] > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq_mem[i][rq_head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    // Called on a negedge; returns on the following negedge.
    task automatic tick();
        uart_step();
        drive_reqs();
        #1;
        model_compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_until(input int unsigned want_sent, input int unsigned budget,
                             input string name);
        int unsigned k;
        k = 0;
        while (!(sent_cnt == 16'(want_sent) && !arb_busy) && k < budget) begin
            tick();
            k++;
        end
        check(name, {16'd0, sent_cnt}, want_sent);
    endtask

    initial begin
        int cnt;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        u_wait    = -1;
        u_left    = 0;
        u_ignore  = 1'b0;
        u_dead    = 1'b0;
        u_rand    = 1'b0;
        u_hold    = 0;
        cyc       = 0;
        clear_queues();
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check("reset_tx_start", {31'd0, tx_start}, 0);
        check("reset_arb_busy", {31'd0, arb_busy}, 0);
        check("reset_sent_cnt", {16'd0, sent_cnt}, 0);
        check("reset_grant_id", {29'd0, grant_id}, 0);
        check("reset_err", {31'd0, err_timeout}, 0);
        check("reset_tx_data", {24'd0, tx_data}, 0);
        check("reset_ready", {29'd0, req_ready}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, long UART busy.
        u_hold = 100;
        push(0, 8'd61);
        tick();
        check("single_start_latency", {31'd0, tx_start}, 1);
        check("single_tx_data", {24'd0, tx_data}, 61);
        run_until(1, 300, "single_sent_cnt");
        check("single_byte", log_at(0), 61);
        check("single_grant", {29'd0, grant_id}, 0);
        check("single_idle", {31'd0, arb_busy}, 0);

        // Watchdog: UART never raises busy.
        u_hold = 2;
        u_dead = 1'b1;
        push(1, 8'hAB);
        tick();
        check("wd_start", {31'd0, tx_start}, 1);
        cnt = 0;
        while (!err_timeout && cnt < 40) begin
            tick();
            cnt++;
        end
        check("wd_latency", cnt, 16);
        check("wd_sent_unchanged", {16'd0, sent_cnt}, 1);
        check("wd_idle", {31'd0, arb_busy}, 0);
        u_dead = 1'b0;
        u_log.delete();
        push(0, 8'h55);
        push(2, 8'h66);
        run_until(3, 200, "wd_after_sent");
        check("wd_next_first", log_at(0), 32'h66);
        check("wd_next_second", log_at(1), 32'h55);

        // Burst bound: requester 1 streams 1..6, requester 2 holds 0x77.
        u_log.delete();
        for (int b = 1; b <= 6; b++) push(1, 8'(b));
        push(2, 8'h77);
        run_until(10, 400, "burst_sent");
        check("burst_b0", log_at(0), 1);
        check("burst_b1", log_at(1), 2);
        check("burst_b2", log_at(2), 3);
        check("burst_b3", log_at(3), 4);
        check("burst_b4", log_at(4), 32'h77);
        check("burst_b5", log_at(5), 5);
        check("burst_b6", log_at(6), 6);

        // Async reset while waiting on the UART.
        u_hold = 20;
        push(2, 8'h99);
        cnt = 0;
        while (m_phase != P_WAIT && cnt < 30) begin
            tick();
            cnt++;
        end
        check("rst_reach_wait", {31'd0, arb_busy}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_arb_busy", {31'd0, arb_busy}, 0);
        check("rst_sent_cnt", {16'd0, sent_cnt}, 0);
        check("rst_grant", {29'd0, grant_id}, 0);
        model_reset();
        clear_queues();
        req_valid = '0;
        tx_busy   = 1'b0;
        u_wait    = -1;
        u_left    = 0;
        u_ignore  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        u_hold = 0;
        u_log.delete();
        push(1, 8'h42);
        run_until(1, 100, "post_rst_sent");
        check("post_rst_byte", log_at(0), 32'h42);

        // Randomised traffic with withdrawals and occasional UART no-shows.
        u_rand = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (rq_cnt[i] < 40 && $urandom_range(0, 5) == 0) begin
                    int nb;
                    nb = int'($urandom_range(1, 6));
                    for (int b = 0; b < nb; b++) push(i, 8'($urandom));
                end
                rq_en[i] = ($urandom_range(0, 15) != 0);
            end
            tick();
        end
        for (int i = 0; i < N; i++) rq_en[i] = 1'b1;
        repeat (300) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
